// File: rtl/aig_vector_sweeper.sv
// Exhaustive input sweeper for a combinational netlist; folds every
// output vector into a Galois MISR so netlist variants compare by signature.
module aig_vector_sweeper #(
    parameter int                N_IN          = 4,
    parameter int                N_OUT         = 20,
    parameter logic [N_OUT-1:0]  MISR_POLY     = 20'h00009,
    parameter logic [N_OUT-1:0]  MISR_SEED     = 20'h00000,
    parameter int                SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   dut_x,
    input  logic [N_OUT-1:0]  dut_f,
    output logic              busy,
    output logic              done,
    output logic [N_OUT-1:0]  signature,
    output logic [N_IN:0]     vec_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [N_IN-1:0] X_LAST      = '1;
    localparam logic [7:0]      SETTLE_INIT = 8'(SETTLE_CYCLES);

    logic [1:0]       state_q,  state_d;
    logic [N_IN-1:0]  x_q,      x_d;
    logic [N_OUT-1:0] sig_q,    sig_d;
    logic [N_IN:0]    cnt_q,    cnt_d;
    logic [7:0]       settle_q, settle_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [N_OUT-1:0] sig_shift;

    // Galois step: shift left, fold taps back in when the MSB falls out
    always_comb begin
        sig_shift = {sig_q[N_OUT-2:0], 1'b0};
        if (sig_q[N_OUT-1]) begin
            sig_shift = sig_shift ^ MISR_POLY;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_SETTLE;
                    x_d      = '0;
                    sig_d    = MISR_SEED;
                    cnt_d    = '0;
                    settle_d = SETTLE_INIT;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            S_SETTLE: begin
                if (settle_q <= 8'd1) begin
                    state_d  = S_CAPTURE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            S_CAPTURE: begin
                sig_d = sig_shift ^ dut_f;
                cnt_d = cnt_q + (N_IN+1)'(1);
                if (x_q == X_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d  = S_SETTLE;
                    x_d      = x_q + N_IN'(1);
                    settle_d = SETTLE_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dut_x     = x_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;
    assign vec_count = cnt_q;

endmodule
